// File: rtl/slot_arbiter_if.sv
// Lane-side and downstream signal bundle for slot_arbiter.
// slave is the arbiter's view; master is the buffers/downstream view.
interface slot_arbiter_if #(
   parameter int NUM_REQ = 4,
   parameter int DATA_W  = 32
);
   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   logic [NUM_REQ-1:0]        req;
   logic [NUM_REQ-1:0]        in_valid;
   logic [NUM_REQ*DATA_W-1:0] in_data;
   logic [NUM_REQ-1:0]        buf_full;
   logic                      stall_in;
   logic [NUM_REQ-1:0]        grant;
   logic                      out_valid;
   logic [DATA_W-1:0]         out_data;
   logic [IDX_W-1:0]          out_src;
   logic                      stall_out;

   modport master (
      output req, in_valid, in_data, buf_full, stall_in,
      input  grant, out_valid, out_data, out_src, stall_out
   );

   modport slave (
      input  req, in_valid, in_data, buf_full, stall_in,
      output grant, out_valid, out_data, out_src, stall_out
   );
endinterface

// File: rtl/slot_arbiter.sv
// Round-robin, quantum-limited grant arbiter over buffer lanes with a registered output stream.
// Define ARB_FIXED_PRIO_EN to replace round robin with fixed lowest-index priority.
//
// state | meaning
// IDLE  | no lane granted, grant = 0
// GRANT | grant one-hot at idx_q
module slot_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int DATA_W  = 32,
   parameter int QUANTUM = 2
) (
   input logic           clk,
   input logic           reset,
   input logic           flush,
   slot_arbiter_if.slave bus
);
   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);
   localparam logic [3:0]       QLIM     = 4'(QUANTUM - 1);

   typedef enum logic {IDLE, GRANT} state_t;

   state_t             state_q, state_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [IDX_W-1:0]   ptr_q, ptr_d;
   logic [3:0]         cnt_q, cnt_d;
   logic [NUM_REQ-1:0] grant_q, grant_d;
   logic               cap_en_q;
   logic [IDX_W-1:0]   cap_idx_q;
   logic               cap_valid;
   logic               out_valid_q;
   logic [DATA_W-1:0]  out_data_q;
   logic [IDX_W-1:0]   out_src_q;
   logic               pick_found;
   logic [IDX_W-1:0]   pick_sel;
   logic [DATA_W-1:0]  lane_data [NUM_REQ];

   for (genvar k = 0; k < NUM_REQ; k++) begin : g_lane
      assign lane_data[k] = bus.in_data[k*DATA_W +: DATA_W];
   end

   // First set request scanning upward from start, wrapping; MSB flags a hit.
   function automatic logic [IDX_W:0] pick(input logic [NUM_REQ-1:0] r,
                                           input logic [IDX_W-1:0]   start);
      logic             found;
      logic [IDX_W-1:0] sel;
      logic [IDX_W-1:0] pi;
      found = 1'b0;
      sel   = start;
      for (int i = 0; i < NUM_REQ; i++) begin
         pi = IDX_W'((int'(start) + i) % NUM_REQ);
         if (!found && r[pi]) begin
            found = 1'b1;
            sel   = pi;
         end
      end
      return {found, sel};
   endfunction

   function automatic logic [IDX_W-1:0] inc_mod(input logic [IDX_W-1:0] v);
      return (v == LAST_IDX) ? '0 : v + IDX_W'(1);
   endfunction

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      ptr_d   = ptr_q;
      cnt_d   = cnt_q;
`ifdef ARB_FIXED_PRIO_EN
      {pick_found, pick_sel} = pick(bus.req, '0);
      ptr_d = '0;
      cnt_d = '0;
      if (pick_found && !bus.stall_in) begin
         state_d = GRANT;
         idx_d   = pick_sel;
      end else begin
         state_d = IDLE;
      end
`else
      // ptr_q holds the next search start, i.e. last granted index + 1
      {pick_found, pick_sel} = pick(bus.req, ptr_q);
      case (state_q)
         IDLE: begin
            if (pick_found && !bus.stall_in) begin
               state_d = GRANT;
               idx_d   = pick_sel;
               ptr_d   = inc_mod(pick_sel);
               cnt_d   = '0;
            end
         end
         GRANT: begin
            if (bus.stall_in || !pick_found) begin
               state_d = IDLE;
            end else if (bus.req[idx_q] && (cnt_q < QLIM)) begin
               cnt_d = cnt_q + 4'd1;
            end else begin
               // a sole requester wraps back to itself and just restarts its quantum
               idx_d = pick_sel;
               ptr_d = inc_mod(pick_sel);
               cnt_d = '0;
            end
         end
         default: state_d = IDLE;
      endcase
`endif
      grant_d = '0;
      if (state_d == GRANT) grant_d[idx_d] = 1'b1;
   end

   assign cap_valid = cap_en_q & bus.in_valid[cap_idx_q];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         idx_q       <= '0;
         ptr_q       <= '0;
         cnt_q       <= '0;
         grant_q     <= '0;
         cap_en_q    <= 1'b0;
         cap_idx_q   <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_src_q   <= '0;
      end else if (flush) begin
         state_q     <= IDLE;
         idx_q       <= '0;
         ptr_q       <= '0;
         cnt_q       <= '0;
         grant_q     <= '0;
         cap_en_q    <= 1'b0;
         cap_idx_q   <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_src_q   <= '0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         ptr_q       <= ptr_d;
         cnt_q       <= cnt_d;
         grant_q     <= grant_d;
         cap_en_q    <= (state_q == GRANT);
         cap_idx_q   <= idx_q;
         out_valid_q <= cap_valid;
         if (cap_valid) begin
            out_data_q <= lane_data[cap_idx_q];
            out_src_q  <= cap_idx_q;
         end
      end
   end

   assign bus.grant     = grant_q;
   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;
   assign bus.out_src   = out_src_q;
   assign bus.stall_out = |bus.buf_full;
endmodule
